// File: rtl/hamming_scrub_ctrl.sv
// Scrub sequencer for the Hamming-protected counter: gates counting,
// runs periodic checks, drives corrections with bounded retry, keeps stats.
module hamming_scrub_ctrl #(
  parameter int SYN_W        = 5,
  parameter int SCRUB_PERIOD = 16,
  parameter int MAX_RETRY    = 3,
  parameter int ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                err_single,
  input  logic                err_double,
  input  logic [SYN_W-1:0]    syndrome,
  input  logic                corr_ack,
  input  logic                clear_fault,
  output logic                count_en,
  output logic                corr_req,
  output logic [SYN_W-1:0]    corr_syndrome,
  output logic                scrub_active,
  output logic                fault,
  output logic [ERRCNT_W-1:0] single_cnt,
  output logic [ERRCNT_W-1:0] double_cnt
);

  localparam int PW = $clog2(SCRUB_PERIOD + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CHECK,
    CORRECT,
    VERIFY,
    FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       period_q, period_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [SYN_W-1:0]    syn_q, syn_d;
  logic [ERRCNT_W-1:0] single_q, single_d;
  logic [ERRCNT_W-1:0] double_q, double_d;
  logic                err_any;

  assign err_any = err_single | err_double;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      retry_q  <= '0;
      syn_q    <= '0;
      single_q <= '0;
      double_q <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      retry_q  <= retry_d;
      syn_q    <= syn_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    retry_d      = retry_q;
    syn_d        = syn_q;
    single_d     = single_q;
    double_d     = double_q;
    count_en     = 1'b0;
    corr_req     = 1'b0;
    scrub_active = 1'b0;
    fault        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (err_any)
          state_d = CHECK;
        else if (enable)
          state_d = RUN;
      end
      RUN: begin
        count_en = enable & ~err_any;
        if (err_any) begin
          state_d = CHECK;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          period_d = period_q + PW'(1);
          if (period_q == PW'(SCRUB_PERIOD - 1))
            state_d = CHECK;
        end
      end
      CHECK: begin
        scrub_active = 1'b1;
        if (err_double) begin
          state_d = FAULT;
          if (double_q != '1)
            double_d = double_q + ERRCNT_W'(1);
        end else if (err_single) begin
          state_d = CORRECT;
          syn_d   = syndrome;
          retry_d = '0;
          if (single_q != '1)
            single_d = single_q + ERRCNT_W'(1);
        end else begin
          period_d = '0;
          state_d  = enable ? RUN : IDLE;
        end
      end
      CORRECT: begin
        scrub_active = 1'b1;
        corr_req     = 1'b1;
        if (corr_ack)
          state_d = VERIFY;
      end
      VERIFY: begin
        scrub_active = 1'b1;
        if (err_double) begin
          state_d = FAULT;
          if (double_q != '1)
            double_d = double_q + ERRCNT_W'(1);
        end else if (err_single) begin
          // Retries are re-attempts of the same error, so no stat bump
          if (retry_q < RW'(MAX_RETRY - 1)) begin
            retry_d = retry_q + RW'(1);
            syn_d   = syndrome;
            state_d = CORRECT;
          end else begin
            state_d = FAULT;
          end
        end else begin
          period_d = '0;
          state_d  = enable ? RUN : IDLE;
        end
      end
      FAULT: begin
        fault = 1'b1;
        if (clear_fault) begin
          state_d  = IDLE;
          retry_d  = '0;
          period_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign corr_syndrome = syn_q;
  assign single_cnt    = single_q;
  assign double_cnt    = double_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with hand-computed expectations.
module tb_hamming_scrub_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       err_single;
  logic       err_double;
  logic [4:0] syndrome;
  logic       corr_ack;
  logic       clear_fault;
  logic       count_en;
  logic       corr_req;
  logic [4:0] corr_syndrome;
  logic       scrub_active;
  logic       fault;
  logic [7:0] single_cnt;
  logic [7:0] double_cnt;

  int checks;
  int errors;

  hamming_scrub_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .err_single    (err_single),
    .err_double    (err_double),
    .syndrome      (syndrome),
    .corr_ack      (corr_ack),
    .clear_fault   (clear_fault),
    .count_en      (count_en),
    .corr_req      (corr_req),
    .corr_syndrome (corr_syndrome),
    .scrub_active  (scrub_active),
    .fault         (fault),
    .single_cnt    (single_cnt),
    .double_cnt    (double_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    enable      = 1'b0;
    err_single  = 1'b0;
    err_double  = 1'b0;
    syndrome    = 5'h00;
    corr_ack    = 1'b0;
    clear_fault = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({count_en, corr_req, scrub_active, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {count_en, corr_req, scrub_active, fault});
    end
    checks++;
    if ({corr_syndrome, single_cnt, double_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL reset_regs: got syn=%h s=%0d d=%0d want 0",
               corr_syndrome, single_cnt, double_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_run_period();
    logic exp_ce;
    do_reset();
    enable = 1'b1;
    #1;
    checks++;
    if (count_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_ce: got %b want 0", count_en);
    end
    for (int i = 0; i < 40; i++) begin
      nxt();
      exp_ce = ((i % 17) != 16);
      checks++;
      if (count_en !== exp_ce || scrub_active !== !exp_ce) begin
        errors++;
        $display("FAIL run_pattern[%0d]: got ce=%b sa=%b want ce=%b sa=%b",
                 i, count_en, scrub_active, exp_ce, !exp_ce);
      end
    end
    checks++;
    if (fault !== 1'b0 || single_cnt !== 8'd0 || double_cnt !== 8'd0) begin
      errors++;
      $display("FAIL run_clean: got f=%b s=%0d d=%0d want 0 0 0",
               fault, single_cnt, double_cnt);
    end
  endtask

  task automatic test_single_correct();
    int req_cycles;
    req_cycles = 0;
    do_reset();
    enable = 1'b1;
    nxt();
    nxt();
    nxt();
    nxt();
    err_single = 1'b1;
    syndrome   = 5'h0B;
    #1;
    checks++;
    if (count_en !== 1'b0) begin
      errors++;
      $display("FAIL err_gate_ce: got %b want 0", count_en);
    end
    nxt();
    checks++;
    if (scrub_active !== 1'b1 || corr_req !== 1'b0) begin
      errors++;
      $display("FAIL check_state: got sa=%b req=%b want 1 0",
               scrub_active, corr_req);
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 2) corr_ack = 1'b1;
      if (corr_req === 1'b1) req_cycles++;
      checks++;
      if (corr_syndrome !== 5'h0B) begin
        errors++;
        $display("FAIL corr_syn[%0d]: got %h want 0b", i, corr_syndrome);
      end
    end
    nxt();
    corr_ack   = 1'b0;
    err_single = 1'b0;
    #1;
    checks++;
    if (req_cycles != 3 || corr_req !== 1'b0) begin
      errors++;
      $display("FAIL req_len: got %0d req=%b want 3 0", req_cycles, corr_req);
    end
    checks++;
    if (scrub_active !== 1'b1 || count_en !== 1'b0) begin
      errors++;
      $display("FAIL verify_state: got sa=%b ce=%b want 1 0",
               scrub_active, count_en);
    end
    checks++;
    if (single_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_cnt1: got %0d want 1", single_cnt);
    end
    nxt();
    checks++;
    if (count_en !== 1'b1 || scrub_active !== 1'b0) begin
      errors++;
      $display("FAIL resume: got ce=%b sa=%b want 1 0", count_en, scrub_active);
    end
  endtask

  task automatic test_retry_fault();
    int pulses;
    pulses = 0;
    do_reset();
    enable = 1'b1;
    nxt();
    err_single = 1'b1;
    syndrome   = 5'h15;
    corr_ack   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (corr_req === 1'b1) pulses++;
      nxt();
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL retry_pulses: got %0d want 3", pulses);
    end
    checks++;
    if (fault !== 1'b1 || count_en !== 1'b0 || corr_req !== 1'b0) begin
      errors++;
      $display("FAIL retry_fault: got f=%b ce=%b req=%b want 1 0 0",
               fault, count_en, corr_req);
    end
    checks++;
    if (single_cnt !== 8'd1 || double_cnt !== 8'd0) begin
      errors++;
      $display("FAIL retry_stats: got s=%0d d=%0d want 1 0",
               single_cnt, double_cnt);
    end
    err_single  = 1'b0;
    corr_ack    = 1'b0;
    clear_fault = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: got %b want 1", fault);
    end
    nxt();
    clear_fault = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || count_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: got f=%b ce=%b want 0 0", fault, count_en);
    end
    nxt();
    checks++;
    if (count_en !== 1'b1 || single_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clear_run: got ce=%b s=%0d want 1 1", count_en, single_cnt);
    end
  endtask

  task automatic test_double_idle();
    do_reset();
    err_single = 1'b1;
    err_double = 1'b1;
    nxt();
    checks++;
    if (scrub_active !== 1'b1 || corr_req !== 1'b0) begin
      errors++;
      $display("FAIL dbl_check: got sa=%b req=%b want 1 0",
               scrub_active, corr_req);
    end
    nxt();
    checks++;
    if (fault !== 1'b1 || corr_req !== 1'b0 || scrub_active !== 1'b0) begin
      errors++;
      $display("FAIL dbl_fault: got f=%b req=%b sa=%b want 1 0 0",
               fault, corr_req, scrub_active);
    end
    checks++;
    if (double_cnt !== 8'd1 || single_cnt !== 8'd0) begin
      errors++;
      $display("FAIL dbl_stats: got d=%0d s=%0d want 1 0",
               double_cnt, single_cnt);
    end
  endtask

  task automatic test_enable_gap();
    int ce_cnt;
    int idle_sa;
    bit seen;
    ce_cnt  = 0;
    idle_sa = 0;
    seen    = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) nxt();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (scrub_active === 1'b1 || count_en === 1'b1) idle_sa++;
      nxt();
    end
    checks++;
    if (idle_sa != 0) begin
      errors++;
      $display("FAIL gap_idle: got %0d active cycles want 0", idle_sa);
    end
    enable = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      nxt();
      if (scrub_active === 1'b1) seen = 1'b1;
      else if (count_en === 1'b1) ce_cnt++;
    end
    checks++;
    if (!seen || ce_cnt != 9) begin
      errors++;
      $display("FAIL gap_resume: got ce=%0d seen=%b want 9 1", ce_cnt, seen);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    nxt();
    err_single = 1'b1;
    syndrome   = 5'h1F;
    nxt();
    nxt();
    checks++;
    if (corr_req !== 1'b1 || corr_syndrome !== 5'h1F || single_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_pre: got req=%b syn=%h s=%0d want 1 1f 1",
               corr_req, corr_syndrome, single_cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({corr_req, scrub_active, count_en, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_flags: got %b want 0000",
               {corr_req, scrub_active, count_en, fault});
    end
    checks++;
    if ({corr_syndrome, single_cnt, double_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL mid_rst_regs: got syn=%h s=%0d d=%0d want 0",
               corr_syndrome, single_cnt, double_cnt);
    end
    #1;
    err_single = 1'b0;
    enable     = 1'b0;
    rst        = 1'b0;
    nxt();
    enable = 1'b1;
    #1;
    checks++;
    if (count_en !== 1'b0 || scrub_active !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got ce=%b sa=%b want 0 0", count_en, scrub_active);
    end
    nxt();
    checks++;
    if (count_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_run: got %b want 1", count_en);
    end
  endtask

  task automatic dbl_round();
    err_double = 1'b1;
    nxt();
    nxt();
    err_double  = 1'b0;
    clear_fault = 1'b1;
    nxt();
    clear_fault = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 254; i++) dbl_round();
    checks++;
    if (double_cnt !== 8'd254) begin
      errors++;
      $display("FAIL sat_pre: got %0d want 254", double_cnt);
    end
    for (int i = 0; i < 6; i++) dbl_round();
    checks++;
    if (double_cnt !== 8'd255 || single_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_hold: got d=%0d s=%0d want 255 0",
               double_cnt, single_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run_period();
    test_single_correct();
    test_retry_fault();
    test_double_idle();
    test_enable_gap();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
